// File: rtl/fetch_redirect_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response port
// plus the valid/ready instruction handoff to decode.
interface fetch_redirect_unit_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_addr,
    output imem_rmask,
    input  imem_rdata,
    input  imem_resp,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_rmask,
    output imem_rdata,
    output imem_resp,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// PC generator / fetch sequencer with redirect squash and output buffer.
// Optional FETCH_PERF_EN adds redirect and squashed-response counters.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h1eceb000,
  parameter int          MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_select,
  input  logic [31:0] pc_branch,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_squashed,
`endif
  fetch_redirect_unit_if.master bus
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT = (CW+1)'(MAX_INFLIGHT);

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] squash;
  logic [CW-1:0] count;
  logic          first;

  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [31:0]   tag_mem [MAX_INFLIGHT];

  logic [AW-1:0] buf_wr;
  logic [AW-1:0] buf_rd;
  logic [31:0]   buf_pc   [MAX_INFLIGHT];
  logic [31:0]   buf_inst [MAX_INFLIGHT];

  logic          credit_ok;
  logic          issue;
  logic          resp;
  logic          keep;
  logic          pop;
  logic          drop;
  logic [31:0]   target;

  always_comb begin
    credit_ok = ({1'b0, inflight} + {1'b0, count}) < CREDIT;
    issue     = rst & ~pc_select & credit_ok;
    // responses before the first post-reset cycle belong to abandoned requests
    resp      = rst & ~first & bus.imem_resp & (inflight != '0);
    keep      = resp & ~pc_select & (squash == '0);
    drop      = resp & ~keep;
    pop       = (count != '0) & bus.inst_ready & ~pc_select;
    target    = pc_branch & ~32'h3;
  end

  always_comb begin
    bus.imem_addr  = pc;
    bus.imem_rmask = {4{issue}};
    bus.inst_valid = (count != '0);
    bus.inst       = '0;
    bus.inst_pc    = '0;
    if (count != '0) begin
      bus.inst    = buf_inst[buf_rd];
      bus.inst_pc = buf_pc[buf_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      squash   <= '0;
      count    <= '0;
      first    <= 1'b1;
      tag_wr   <= '0;
      tag_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      first <= 1'b0;

      if (pc_select)
        pc <= target;
      else if (issue)
        pc <= pc + 32'd4;

      if (issue) begin
        tag_mem[tag_wr] <= pc;
        tag_wr          <= tag_wr + AW'(1);
      end
      if (resp)
        tag_rd <= tag_rd + AW'(1);

      inflight <= inflight + CW'(issue) - CW'(resp);

      // every request still outstanding after a redirect is stale
      if (pc_select)
        squash <= inflight - CW'(resp);
      else if (resp && squash != '0)
        squash <= squash - CW'(1);

      if (pc_select) begin
        count  <= '0;
        buf_wr <= '0;
        buf_rd <= '0;
      end else begin
        if (keep) begin
          buf_pc[buf_wr]   <= tag_mem[tag_rd];
          buf_inst[buf_wr] <= bus.imem_rdata;
          buf_wr           <= buf_wr + AW'(1);
        end
        if (pop)
          buf_rd <= buf_rd + AW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !first && bus.imem_resp)
      assert (inflight != '0);
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_redirects <= '0;
      perf_squashed  <= '0;
    end else begin
      perf_redirects <= perf_redirects + 32'(pc_select);
      perf_squashed  <= perf_squashed + 32'(drop)
                      + (pc_select ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: memory model plus
// in-order expected-PC queue, flushed on redirect and reset.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_select;
  logic [31:0] pc_branch;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_squashed;
`endif

  fetch_redirect_unit_if bus ();

  fetch_redirect_unit #(
    .RESET_PC(RPC),
    .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_select(pc_select),
    .pc_branch(pc_branch),
`ifdef FETCH_PERF_EN
    .perf_redirects(perf_redirects),
    .perf_squashed(perf_squashed),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] pend_q [$];
  logic        hold = 1'b0;
  logic        resp_in_reset = 1'b0;
  logic        nxt_resp = 1'b0;
  logic [31:0] nxt_data = '0;
  logic [31:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h00130013;
  endfunction

  // memory model and scoreboard: sample at negedge, drive after posedge
  initial begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_q.delete();
        pend_q.delete();
        nxt_resp = resp_in_reset;
        nxt_data = 32'hdeadbeef;
      end else begin
        if (bus.inst_valid && bus.inst_ready && !pc_select) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver: got pc %h, required none", bus.inst_pc);
          end else begin
            mon_e = exp_q.pop_front();
            if (bus.inst_pc !== mon_e || bus.inst !== mem_word(mon_e)) begin
              errors++;
              $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h",
                       bus.inst_pc, bus.inst, mon_e, mem_word(mon_e));
            end
          end
        end
        if (pc_select)
          exp_q.delete();
        checks++;
        if (bus.imem_rmask !== 4'h0 &&
            (bus.imem_rmask !== 4'hf || pc_select)) begin
          errors++;
          $display("FAIL rmask: got %h with pc_select %b", bus.imem_rmask, pc_select);
        end
        if (bus.imem_rmask == 4'hf) begin
          exp_q.push_back(bus.imem_addr);
          pend_q.push_back(bus.imem_addr);
        end
        nxt_resp = !hold && pend_q.size() > 0;
        nxt_data = '0;
        if (nxt_resp)
          nxt_data = mem_word(pend_q.pop_front());
      end
      @(posedge clk);
      #1;
      bus.imem_resp  = nxt_resp;
      bus.imem_rdata = nxt_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy, input logic hd);
    rst = 1'b0;
    pc_select = 1'b0;
    bus.inst_ready = rdy;
    hold = hd;
    cyc(3);
    rst = 1'b1;
  endtask

  // stop delivery: DUT must settle with exactly 4 buffered entries
  task automatic drain();
    hold = 1'b0;
    pc_select = 1'b0;
    bus.inst_ready = 1'b0;
    cyc(12);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 4 || bus.inst_valid !== 1'b1 || bus.imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL drain: pending %0d valid %b rmask %h, required 4 1 0",
               exp_q.size(), bus.inst_valid, bus.imem_rmask);
    end
    bus.inst_ready = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(3);
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL reset_rmask: got %h, required 0", bus.imem_rmask);
    end
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", bus.inst_valid);
    end
    checks++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst: got %h/%h, required 0/0", bus.inst, bus.inst_pc);
    end
    checks++;
    if (bus.imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_pc: got %h, required %h", bus.imem_addr, RPC);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_redirects !== 32'h0 || perf_squashed !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d, required 0/0", perf_redirects, perf_squashed);
    end
`endif
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'hf || bus.imem_addr !== RPC + 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr[%0d]: got %h/%h, required f/%h",
                 i, bus.imem_rmask, bus.imem_addr, RPC + 32'(4 * i));
      end
      checks++;
      if (i >= 2) begin
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RPC + 32'(4 * (i - 2))) begin
          errors++;
          $display("FAIL stream_pc[%0d]: got %b/%h, required 1/%h",
                   i, bus.inst_valid, bus.inst_pc, RPC + 32'(4 * (i - 2)));
        end
      end else if (bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_lat[%0d]: got valid %b, required 0", i, bus.inst_valid);
      end
      cyc(1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    logic found;
    logic [31:0] a;
    n = 0;
    found = 1'b0;
    a = '0;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_rmask == 4'hf)
        n++;
      cyc(1);
    end
    @(negedge clk);
    checks++;
    if (n != 4 || bus.imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL bp_credit: got %0d issues rmask %h, required 4 and 0", n, bus.imem_rmask);
    end
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RPC) begin
      errors++;
      $display("FAIL bp_head: got %b/%h, required 1/%h", bus.inst_valid, bus.inst_pc, RPC);
    end
    cyc(1);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!found) begin
        @(negedge clk);
        if (bus.imem_rmask == 4'hf) begin
          found = 1'b1;
          a = bus.imem_addr;
        end else begin
          cyc(1);
        end
      end
    end
    checks++;
    if (a !== RPC + 32'h10) begin
      errors++;
      $display("FAIL bp_resume: got %h, required %h", a, RPC + 32'h10);
    end
    cyc(1);
    drain();
  endtask

  task automatic first_delivery(input string name, input logic [31:0] want);
    logic found;
    logic [31:0] got;
    found = 1'b0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      if (!found) begin
        cyc(1);
        @(negedge clk);
        if (bus.inst_valid) begin
          found = 1'b1;
          got = bus.inst_pc;
        end
      end
    end
    checks++;
    if (!found || got !== want) begin
      errors++;
      $display("FAIL %s: got found %b pc %h, required pc %h", name, found, got, want);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b1);
    cyc(3);
    pc_select = 1'b1;
    pc_branch = 32'h1eceb102;
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL redir_noissue: got %h, required 0", bus.imem_rmask);
    end
    cyc(1);
    pc_select = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'hf || bus.imem_addr !== 32'h1eceb100) begin
      errors++;
      $display("FAIL redir_target: got %h/%h, required f/1eceb100",
               bus.imem_rmask, bus.imem_addr);
    end
    first_delivery("redir_first", 32'h1eceb100);
    drain();
  endtask

  task automatic test_redirect_resp();
    do_reset(1'b0, 1'b1);
    cyc(5);
    hold = 1'b0;
    cyc(3);
    pc_select = 1'b1;
    pc_branch = 32'h1eceb180;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RPC) begin
      errors++;
      $display("FAIL rr_buffered: got %b/%h, required 1/%h", bus.inst_valid, bus.inst_pc, RPC);
    end
    cyc(1);
    pc_select = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_flush: got valid %b, required 0", bus.inst_valid);
    end
    checks++;
    if (bus.imem_rmask !== 4'hf || bus.imem_addr !== 32'h1eceb180) begin
      errors++;
      $display("FAIL rr_target: got %h/%h, required f/1eceb180",
               bus.imem_rmask, bus.imem_addr);
    end
    first_delivery("rr_first", 32'h1eceb180);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1, 1'b0);
    cyc(3);
    pc_select = 1'b1;
    pc_branch = 32'h1eceb200;
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL b2b_noissue1: got %h, required 0", bus.imem_rmask);
    end
    cyc(1);
    pc_branch = 32'h1eceb300;
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'h0 || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_noissue2: got %h/%b, required 0/0", bus.imem_rmask, bus.inst_valid);
    end
    cyc(1);
    pc_select = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_rmask !== 4'hf || bus.imem_addr !== 32'h1eceb300) begin
      errors++;
      $display("FAIL b2b_target: got %h/%h, required f/1eceb300",
               bus.imem_rmask, bus.imem_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_redirects !== 32'd2 || perf_squashed !== 32'd2) begin
      errors++;
      $display("FAIL b2b_perf: got %0d/%0d, required 2/2", perf_redirects, perf_squashed);
    end
`endif
    first_delivery("b2b_first", 32'h1eceb300);
    drain();
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b1, 1'b1);
    cyc(2);
    rst = 1'b0;
    hold = 1'b0;
    resp_in_reset = 1'b1;
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    resp_in_reset = 1'b0;
    checks++;
    if (bus.imem_rmask !== 4'hf || bus.imem_addr !== RPC || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: got %h/%h/%b, required f/%h/0",
               bus.imem_rmask, bus.imem_addr, bus.inst_valid, RPC);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_redirects !== 32'h0 || perf_squashed !== 32'h0) begin
      errors++;
      $display("FAIL mid_perf: got %0d/%0d, required 0/0", perf_redirects, perf_squashed);
    end
`endif
    first_delivery("mid_first", RPC);
    checks++;
    if (bus.inst !== mem_word(RPC)) begin
      errors++;
      $display("FAIL mid_data: got %h, required %h", bus.inst, mem_word(RPC));
    end
    drain();
  endtask

  initial begin
    rst = 1'b0;
    pc_select = 1'b0;
    pc_branch = '0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_resp();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
